// File: rtl/mul_pkg.sv
// Shared types and step tables for the 16x16 sequential multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_STEPS = 4;

    localparam logic [4:0] SHIFT_TBL [0:NUM_STEPS-1] = '{
        5'd0, 5'd8, 5'd8, 5'd16
    };

    // {a_hi, b_hi} byte selects per step
    localparam logic [1:0] SEL_TBL [0:NUM_STEPS-1] = '{
        2'b00, 2'b10, 2'b01, 2'b11
    };

endpackage

// File: rtl/mul16_seq_ctrl_dadda_8.sv
// 8x8 unsigned multiplier shared by the sequencer.
module dadda_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] y
);

    assign y = 16'(a) * 16'(b);

endmodule

// File: rtl/mul16_seq_ctrl.sv
// 16x16 unsigned multiply built from four 8x8 products over four cycles.
module mul16_seq_ctrl
    import mul_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    state_t state;
    state_t state_nx;

    logic [15:0]      a_q;
    logic [15:0]      b_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      acc;
    logic [1:0]       step;
    logic [31:0]      p_q;
    logic [TAG_W-1:0] otag_q;

    logic             accept;
    logic             last_step;
    logic [1:0]       sel;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [15:0]      prod;
    logic [31:0]      acc_nx;

    dadda_8 u_mul (
        .a (op_a),
        .b (op_b),
        .y (prod)
    );

    always_comb begin
        sel    = SEL_TBL[step];
        op_a   = sel[1] ? a_q[15:8] : a_q[7:0];
        op_b   = sel[0] ? b_q[15:8] : b_q[7:0];
        acc_nx = acc + (32'(prod) << SHIFT_TBL[step]);
    end

    assign in_ready  = (state == IDLE) ||
                       (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_step = (step == 2'(NUM_STEPS - 1));
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_p     = p_q;
    assign out_tag   = otag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = MUL;
            end
            MUL: begin
                if (last_step) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = accept ? MUL : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            tag_q  <= '0;
            acc    <= '0;
            step   <= '0;
            p_q    <= '0;
            otag_q <= '0;
        end else if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
            acc   <= '0;
            step  <= '0;
        end else if (state == MUL) begin
            acc  <= acc_nx;
            step <= step + 2'd1;
            // result registers are loaded once so they stay put in DONE/IDLE
            if (last_step) begin
                p_q    <= acc_nx;
                otag_q <= tag_q;
            end
        end
    end

endmodule
